axi_access_scheduler: RTL and testbench

//  Single-outstanding access scheduler between the CPU memory clients and the bus-side adapters.

---
 rtl/axi_access_scheduler_if.sv | 45 ++++
 rtl/axi_access_scheduler.sv | 151 +++++++++++++++
 tb/tb_axi_access_scheduler.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_access_scheduler_if.sv
// Client-side and bus-side handshake bundle for the access scheduler.
// The scheduler takes the master view; clients and bus adapters take the slave view.
interface axi_access_scheduler_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_addr_ok;
    logic        if_data_ok;
    logic [31:0] if_rdata;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    modport master (
        input  if_req, if_addr,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  bus_addr_ok, bus_data_ok, bus_rdata,
        output if_addr_ok, if_data_ok, if_rdata,
        output mem_addr_ok, mem_data_ok, mem_rdata,
        output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb
    );

    modport slave (
        output if_req, if_addr,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output bus_addr_ok, bus_data_ok, bus_rdata,
        input  if_addr_ok, if_data_ok, if_rdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata,
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb
    );
endinterface

// File: rtl/axi_access_scheduler.sv
// Single-outstanding scheduler arbitrating IF and MEM accesses onto one bus port,
// with kseg0/kseg1 unmapping, flush-discard of IF completions and MEM starvation limit.
module axi_access_scheduler #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    axi_access_scheduler_if.master        acc,
    output logic                          busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        IF_ADDR  = 3'd1,
        IF_DATA  = 3'd2,
        MEM_ADDR = 3'd3,
        MEM_DATA = 3'd4
    } state_t;

    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

    state_t      state_reg;
    state_t      state_next;
    logic        discard_reg;
    logic [2:0]  starve_cnt_reg;
    logic        we_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  wstrb_reg;
    logic        if_data_ok_reg;
    logic        mem_data_ok_reg;
    logic [31:0] if_rdata_reg;
    logic [31:0] mem_rdata_reg;

    logic        if_eligible;
    logic        if_grant;
    logic        mem_grant;

    // kseg0/kseg1 both alias the low 512 MB of physical space
    function automatic logic [31:0] unmap(input logic [31:0] va);
        if (va[31:29] == 3'b100 || va[31:29] == 3'b101)
            unmap = {3'b000, va[28:0]};
        else
            unmap = va;
    endfunction

    always_comb begin
        state_next  = state_reg;
        if_eligible = 1'b0;
        if_grant    = 1'b0;
        mem_grant   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (reset) begin
                    // A flushed IF request does not block MEM from taking the slot
                    if_eligible = acc.if_req & ~flush;
                    mem_grant   = acc.mem_req &
                                  ((starve_cnt_reg < STARVE_MAX) | ~if_eligible);
                    if_grant    = if_eligible & ~mem_grant;
                end
                if (mem_grant)
                    state_next = MEM_ADDR;
                else if (if_grant)
                    state_next = IF_ADDR;
            end
            IF_ADDR:  if (acc.bus_addr_ok) state_next = IF_DATA;
            IF_DATA:  if (acc.bus_data_ok) state_next = IDLE;
            MEM_ADDR: if (acc.bus_addr_ok) state_next = MEM_DATA;
            MEM_DATA: if (acc.bus_data_ok) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            discard_reg     <= 1'b0;
            starve_cnt_reg  <= 3'd0;
            we_reg          <= 1'b0;
            addr_reg        <= 32'd0;
            wdata_reg       <= 32'd0;
            wstrb_reg       <= 4'd0;
            if_data_ok_reg  <= 1'b0;
            mem_data_ok_reg <= 1'b0;
            if_rdata_reg    <= 32'd0;
            mem_rdata_reg   <= 32'd0;
        end else begin
            state_reg       <= state_next;
            if_data_ok_reg  <= 1'b0;
            mem_data_ok_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    discard_reg <= 1'b0;
                    if (mem_grant) begin
                        we_reg    <= acc.mem_we;
                        addr_reg  <= unmap(acc.mem_addr);
                        wdata_reg <= acc.mem_wdata;
                        wstrb_reg <= acc.mem_wstrb;
                    end else if (if_grant) begin
                        we_reg    <= 1'b0;
                        addr_reg  <= unmap(acc.if_addr);
                        wdata_reg <= 32'd0;
                        wstrb_reg <= 4'd0;
                    end
                    if (if_grant || !acc.if_req)
                        starve_cnt_reg <= 3'd0;
                    else if (mem_grant && starve_cnt_reg != 3'd7)
                        starve_cnt_reg <= starve_cnt_reg + 3'd1;
                end
                IF_ADDR: begin
                    if (flush)
                        discard_reg <= 1'b1;
                end
                IF_DATA: begin
                    if (acc.bus_data_ok) begin
                        // A flush arriving with the data still kills the completion
                        if (!discard_reg && !flush) begin
                            if_data_ok_reg <= 1'b1;
                            if_rdata_reg   <= acc.bus_rdata;
                        end
                        discard_reg <= 1'b0;
                    end else if (flush) begin
                        discard_reg <= 1'b1;
                    end
                end
                MEM_DATA: begin
                    if (acc.bus_data_ok) begin
                        mem_data_ok_reg <= 1'b1;
                        mem_rdata_reg   <= we_reg ? 32'd0 : acc.bus_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign acc.if_addr_ok  = if_grant;
    assign acc.mem_addr_ok = mem_grant;
    assign acc.if_data_ok  = if_data_ok_reg;
    assign acc.if_rdata    = if_rdata_reg;
    assign acc.mem_data_ok = mem_data_ok_reg;
    assign acc.mem_rdata   = mem_rdata_reg;
    assign acc.bus_req     = (state_reg == IF_ADDR) || (state_reg == MEM_ADDR);
    assign acc.bus_we      = we_reg;
    assign acc.bus_addr    = addr_reg;
    assign acc.bus_wdata   = wdata_reg;
    assign acc.bus_wstrb   = wstrb_reg;
    assign busy            = (state_reg != IDLE);

endmodule

// File: tb/tb_axi_access_scheduler.sv
// Directed bench for axi_access_scheduler: inputs change and outputs are checked just after
// the falling edge, so every combinational and registered value is stable when compared.
module tb_axi_access_scheduler;

    logic clk;
    logic reset;
    logic flush;
    logic busy;
    int   total;
    int   bad;

    axi_access_scheduler_if sif ();

    axi_access_scheduler #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .acc   (sif.master),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic bus_accept();
        sif.bus_addr_ok = 1'b1;
        tick();
        sif.bus_addr_ok = 1'b0;
    endtask

    task automatic bus_return(input logic [31:0] d);
        sif.bus_data_ok = 1'b1;
        sif.bus_rdata   = d;
        tick();
        sif.bus_data_ok = 1'b0;
        sif.bus_rdata   = 32'd0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        flush = 1'b0;
        sif.if_req      = 1'b1;
        sif.if_addr     = 32'hBFC00000;
        sif.mem_req     = 1'b1;
        sif.mem_we      = 1'b0;
        sif.mem_addr    = 32'h80000000;
        sif.mem_wdata   = 32'd0;
        sif.mem_wstrb   = 4'd0;
        sif.bus_addr_ok = 1'b0;
        sif.bus_data_ok = 1'b0;
        sif.bus_rdata   = 32'd0;

        // Reset state: all outputs low, requests not accepted while reset is held
        tick(); #1;
        chk("rst_busy", busy, 0);
        chk("rst_bus_req", sif.bus_req, 0);
        chk("rst_bus_addr", sif.bus_addr, 0);
        chk("rst_if_addr_ok", sif.if_addr_ok, 0);
        chk("rst_mem_addr_ok", sif.mem_addr_ok, 0);
        sif.if_req  = 1'b0;
        sif.mem_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // 1: IF read of kseg1 boot vector
        sif.if_req  = 1'b1;
        sif.if_addr = 32'hBFC00000;
        #1;
        chk("t1_if_addr_ok", sif.if_addr_ok, 1);
        chk("t1_mem_addr_ok", sif.mem_addr_ok, 0);
        tick();
        sif.if_req = 1'b0;
        #1;
        chk("t1_bus_req", sif.bus_req, 1);
        chk("t1_bus_addr", sif.bus_addr, 32'h1FC00000);
        chk("t1_bus_we", sif.bus_we, 0);
        chk("t1_busy", busy, 1);
        chk("t1_if_addr_ok_busy", sif.if_addr_ok, 0);
        bus_accept();
        #1;
        chk("t1_bus_req_drop", sif.bus_req, 0);
        chk("t1_if_data_ok_early", sif.if_data_ok, 0);
        bus_return(32'h24080001);
        #1;
        chk("t1_if_data_ok", sif.if_data_ok, 1);
        chk("t1_if_rdata", sif.if_rdata, 32'h24080001);
        chk("t1_busy_idle", busy, 0);
        tick(); #1;
        chk("t1_if_data_ok_pulse", sif.if_data_ok, 0);

        // 2: simultaneous requests, MEM first then IF
        tick();
        sif.if_req   = 1'b1;
        sif.if_addr  = 32'hBFC00100;
        sif.mem_req  = 1'b1;
        sif.mem_we   = 1'b0;
        sif.mem_addr = 32'h80001000;
        #1;
        chk("t2_mem_addr_ok", sif.mem_addr_ok, 1);
        chk("t2_if_addr_ok", sif.if_addr_ok, 0);
        tick();
        sif.mem_req = 1'b0;
        #1;
        chk("t2_bus_addr_mem", sif.bus_addr, 32'h00001000);
        chk("t2_if_addr_ok_busy", sif.if_addr_ok, 0);
        bus_accept();
        bus_return(32'h11223344);
        #1;
        chk("t2_mem_data_ok", sif.mem_data_ok, 1);
        chk("t2_mem_rdata", sif.mem_rdata, 32'h11223344);
        chk("t2_if_addr_ok_after", sif.if_addr_ok, 1);
        tick();
        sif.if_req = 1'b0;
        #1;
        chk("t2_bus_addr_if", sif.bus_addr, 32'h1FC00100);
        chk("t2_mem_data_ok_pulse", sif.mem_data_ok, 0);
        bus_accept();
        bus_return(32'h55667788);
        #1;
        chk("t2_if_data_ok", sif.if_data_ok, 1);
        chk("t2_if_rdata", sif.if_rdata, 32'h55667788);
        tick();

        // 3: starvation limit, four MEM grants then IF
        sif.if_req   = 1'b1;
        sif.if_addr  = 32'h9FC00000;
        sif.mem_req  = 1'b1;
        sif.mem_we   = 1'b0;
        sif.mem_addr = 32'h00002000;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("t3_mem_grant%0d", i), sif.mem_addr_ok, (i < 4) ? 1 : 0);
            chk($sformatf("t3_if_grant%0d", i), sif.if_addr_ok, (i == 4) ? 1 : 0);
            tick(); #1;
            chk($sformatf("t3_bus_addr%0d", i), sif.bus_addr,
                (i < 4) ? 32'h00002000 : 32'h1FC00000);
            bus_accept();
            bus_return(32'h00000100 + i);
            #1;
            chk($sformatf("t3_mem_done%0d", i), sif.mem_data_ok, (i < 4) ? 1 : 0);
            chk($sformatf("t3_if_done%0d", i), sif.if_data_ok, (i == 4) ? 1 : 0);
        end
        chk("t3_mem_regrant", sif.mem_addr_ok, 1);
        sif.if_req  = 1'b0;
        sif.mem_req = 1'b0;
        tick();

        // 4: flush during IF_DATA discards the completion
        sif.if_req  = 1'b1;
        sif.if_addr = 32'hBFC00200;
        #1;
        chk("t4_if_addr_ok", sif.if_addr_ok, 1);
        tick();
        sif.if_req = 1'b0;
        bus_accept();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("t4_busy_data", busy, 1);
        bus_return(32'hCAFEF00D);
        #1;
        chk("t4_if_data_ok_discard", sif.if_data_ok, 0);
        chk("t4_busy_idle", busy, 0);
        sif.if_req  = 1'b1;
        sif.if_addr = 32'hBFC00300;
        flush = 1'b1;
        #1;
        chk("t4_flush_blocks_grant", sif.if_addr_ok, 0);
        flush = 1'b0;
        #1;
        chk("t4_if_addr_ok_next", sif.if_addr_ok, 1);
        tick();
        sif.if_req = 1'b0;
        bus_accept();
        bus_return(32'h12345678);
        #1;
        chk("t4_if_data_ok_next", sif.if_data_ok, 1);
        chk("t4_if_rdata_next", sif.if_rdata, 32'h12345678);
        tick();

        // 5: MEM write with stalled address acceptance
        sif.mem_req   = 1'b1;
        sif.mem_we    = 1'b1;
        sif.mem_addr  = 32'hA0000010;
        sif.mem_wdata = 32'hDEADBEEF;
        sif.mem_wstrb = 4'b0011;
        #1;
        chk("t5_mem_addr_ok", sif.mem_addr_ok, 1);
        tick();
        sif.mem_req   = 1'b0;
        sif.mem_we    = 1'b0;
        sif.mem_addr  = 32'h0;
        sif.mem_wdata = 32'h0;
        sif.mem_wstrb = 4'h0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("t5_bus_req%0d", i), sif.bus_req, 1);
            chk($sformatf("t5_bus_addr%0d", i), sif.bus_addr, 32'h00000010);
            chk($sformatf("t5_bus_wdata%0d", i), sif.bus_wdata, 32'hDEADBEEF);
            chk($sformatf("t5_bus_wstrb%0d", i), sif.bus_wstrb, 4'b0011);
            chk($sformatf("t5_bus_we%0d", i), sif.bus_we, 1);
            tick();
        end
        bus_accept();
        #1;
        chk("t5_bus_req_drop", sif.bus_req, 0);
        tick();
        bus_return(32'hFFFFFFFF);
        #1;
        chk("t5_mem_data_ok", sif.mem_data_ok, 1);
        chk("t5_mem_rdata_write", sif.mem_rdata, 0);
        tick(); #1;
        chk("t5_mem_data_ok_pulse", sif.mem_data_ok, 0);

        // 6: reset asserted in MEM_DATA
        sif.mem_req  = 1'b1;
        sif.mem_we   = 1'b0;
        sif.mem_addr = 32'h80000040;
        tick();
        sif.mem_req = 1'b0;
        bus_accept();
        #1;
        chk("t6_busy_before", busy, 1);
        sif.mem_req = 1'b1;
        reset = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_bus_req", sif.bus_req, 0);
        chk("t6_bus_we", sif.bus_we, 0);
        chk("t6_bus_addr", sif.bus_addr, 0);
        chk("t6_bus_wdata", sif.bus_wdata, 0);
        chk("t6_bus_wstrb", sif.bus_wstrb, 0);
        chk("t6_if_rdata", sif.if_rdata, 0);
        chk("t6_mem_rdata", sif.mem_rdata, 0);
        chk("t6_if_data_ok", sif.if_data_ok, 0);
        chk("t6_mem_data_ok", sif.mem_data_ok, 0);
        chk("t6_mem_addr_ok_rst", sif.mem_addr_ok, 0);
        tick();
        reset = 1'b1;
        #1;
        chk("t6_mem_addr_ok_after", sif.mem_addr_ok, 1);
        tick();
        sif.mem_req = 1'b0;
        #1;
        chk("t6_bus_req_after", sif.bus_req, 1);
        chk("t6_bus_addr_after", sif.bus_addr, 32'h00000040);
        bus_accept();
        bus_return(32'hA5A5A5A5);
        #1;
        chk("t6_mem_data_ok_after", sif.mem_data_ok, 1);
        chk("t6_mem_rdata_after", sif.mem_rdata, 32'hA5A5A5A5);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
